alu_flag_commit: RTL and testbench

Registered commit stage directly downstream of the adder/subtractor with flags. It accepts the adder's result, carry, overflow and zero on a valid/ready handshake and buffers up to two results in a skid FIFO. On commit it updates an architectural NZCV flag register and evaluates a 4-bit condition code against the committed flags. Branch and conditional-select logic consume it.

---
 rtl/alu_flag_commit_if.sv | 37 +++
 rtl/alu_flag_commit.sv | 102 ++++++++++
 tb/tb_alu_flag_commit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_flag_commit_if.sv
// Handshake bundle between the adder, the flag commit stage and its consumer.
//   in_*  : result plus raw adder flags from the adder (valid/ready)
//   out_* : head FIFO entry toward branch / conditional-select logic (valid/ready)
// Modports:
//   master : the side that drives in_* and consumes out_* (adder + consumer, or a bench)
//   slave  : the commit stage itself
interface alu_flag_commit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_overflow;
  logic             in_zero;
  logic             in_set_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_set_flags;

  modport master (
    output in_valid, in_result, in_carry, in_overflow, in_zero, in_set_flags,
    input  in_ready,
    input  out_valid, out_result, out_flags, out_set_flags,
    output out_ready
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_overflow, in_zero, in_set_flags,
    output in_ready,
    output out_valid, out_result, out_flags, out_set_flags,
    input  out_ready
  );
endinterface

// File: rtl/alu_flag_commit.sv
// Commit stage behind the adder/subtractor. Buffers up to two results in a
// skid FIFO, updates the architectural NZCV register when a set_flags entry
// is popped, and evaluates a 4-bit condition code against the committed flags.
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   bus       alu_flag_commit_if.slave (in_* push side, out_* pop side)
//   nzcv      committed flag register {N,Z,C,V}
//   cond_sel  condition code to evaluate
//   cond_true cond_sel evaluated against nzcv
module alu_flag_commit #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_flag_commit_if.slave        bus,
  output logic [3:0]              nzcv,
  input  logic [3:0]              cond_sel,
  output logic                    cond_true
);

  logic [WIDTH-1:0] mem_result [2];
  logic [3:0]       mem_flags  [2];
  logic [1:0]       mem_sf;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic push;
  logic pop;

  // in_ready depends only on the occupancy register (and rst), so a full
  // FIFO refuses a push even when the head is being popped that cycle.
  assign bus.in_ready      = (count != 2'd2) && !rst;
  assign bus.out_valid     = (count != 2'd0);
  assign bus.out_result    = mem_result[rd_ptr];
  assign bus.out_flags     = mem_flags[rd_ptr];
  assign bus.out_set_flags = mem_sf[rd_ptr];

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      nzcv   <= 4'd0;
      mem_sf <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= 4'd0;
      end
    end else begin
      if (push) begin
        // N comes from the result MSB; Z is the adder's own zero flag.
        mem_result[wr_ptr] <= bus.in_result;
        mem_flags[wr_ptr]  <= {bus.in_result[WIDTH-1], bus.in_zero,
                               bus.in_carry, bus.in_overflow};
        mem_sf[wr_ptr]     <= bus.in_set_flags;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem_sf[rd_ptr]) begin
          nzcv <= mem_flags[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      4'd0:  cond_true = flag_z;
      4'd1:  cond_true = !flag_z;
      4'd2:  cond_true = flag_c;
      4'd3:  cond_true = !flag_c;
      4'd4:  cond_true = flag_n;
      4'd5:  cond_true = !flag_n;
      4'd6:  cond_true = flag_v;
      4'd7:  cond_true = !flag_v;
      4'd8:  cond_true = flag_c && !flag_z;
      4'd9:  cond_true = !flag_c || flag_z;
      4'd10: cond_true = (flag_n == flag_v);
      4'd11: cond_true = (flag_n != flag_v);
      4'd12: cond_true = !flag_z && (flag_n == flag_v);
      4'd13: cond_true = flag_z || (flag_n != flag_v);
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_flag_commit.sv
module tb_alu_flag_commit;

  logic       clk;
  logic       rst;
  logic [3:0] nzcv;
  logic [3:0] cond_sel;
  logic       cond_true;

  int n_checks;
  int n_fail;

  alu_flag_commit_if #(.WIDTH(32)) bus ();

  alu_flag_commit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .nzcv      (nzcv),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] r, input logic c,
                          input logic ov, input logic z, input logic sf);
    bus.in_valid     = v;
    bus.in_result    = r;
    bus.in_carry     = c;
    bus.in_overflow  = ov;
    bus.in_zero      = z;
    bus.in_set_flags = sf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    cond_sel = 4'd1;
    drive_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        $display("FAIL reset_in_ready cyc%0d got %b exp 0", i, bus.in_ready); n_fail++;
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        $display("FAIL reset_out_valid cyc%0d got %b exp 0", i, bus.out_valid); n_fail++;
      end
      n_checks++;
      if (nzcv !== 4'b0000) begin
        $display("FAIL reset_nzcv cyc%0d got %b exp 0000", i, nzcv); n_fail++;
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); n_fail++;
    end
    n_checks++;
    if (bus.out_result !== 32'h0 || bus.out_flags !== 4'h0 || bus.out_set_flags !== 1'b0) begin
      $display("FAIL reset_out_fields got %h/%b/%b exp 0/0000/0",
               bus.out_result, bus.out_flags, bus.out_set_flags); n_fail++;
    end
    n_checks++;
    if (cond_true !== 1'b1) begin
      $display("FAIL reset_cond_NE got %b exp 1", cond_true); n_fail++;
    end
    cond_sel = 4'd0; #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      $display("FAIL reset_cond_EQ got %b exp 0", cond_true); n_fail++;
    end
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_commit();
    bus.out_ready = 1'b1;
    cond_sel = 4'd0;
    drive_in(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL single_out_valid got %b exp 1", bus.out_valid); n_fail++;
    end
    n_checks++;
    if (bus.out_flags !== 4'b0110) begin
      $display("FAIL single_out_flags got %b exp 0110", bus.out_flags); n_fail++;
    end
    n_checks++;
    if (nzcv !== 4'b0000 || cond_true !== 1'b0) begin
      $display("FAIL single_precommit got nzcv=%b EQ=%b exp 0000/0", nzcv, cond_true); n_fail++;
    end
    tick();
    n_checks++;
    if (nzcv !== 4'b0110) begin
      $display("FAIL single_nzcv got %b exp 0110", nzcv); n_fail++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL single_drained got %b exp 0", bus.out_valid); n_fail++;
    end
    cond_sel = 4'd0; #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      $display("FAIL single_EQ got %b exp 1", cond_true); n_fail++;
    end
    cond_sel = 4'd2; #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      $display("FAIL single_CS got %b exp 1", cond_true); n_fail++;
    end
    cond_sel = 4'd8; #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      $display("FAIL single_HI got %b exp 0", cond_true); n_fail++;
    end
    cond_sel = 4'd10; #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      $display("FAIL single_GE got %b exp 1", cond_true); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_in(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_in(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL bp_full_in_ready got %b exp 0", bus.in_ready); n_fail++;
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h1) begin
      $display("FAIL bp_hold got in_ready=%b head=%h exp 0/1", bus.in_ready, bus.out_result); n_fail++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL bp_full_pop_in_ready got %b exp 0", bus.in_ready); n_fail++;
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h2) begin
      $display("FAIL bp_second got v=%b r=%h exp 1/2", bus.out_valid, bus.out_result); n_fail++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL bp_reopen got %b exp 1", bus.in_ready); n_fail++;
    end
    tick();
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3) begin
      $display("FAIL bp_third got v=%b r=%h exp 1/3", bus.out_valid, bus.out_result); n_fail++;
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL bp_drained got %b exp 0", bus.out_valid); n_fail++;
    end
    n_checks++;
    if (nzcv !== 4'b0110) begin
      $display("FAIL bp_nzcv_kept got %b exp 0110", nzcv); n_fail++;
    end
  endtask

  task automatic test_set_flags();
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (nzcv !== 4'b1001) begin
      $display("FAIL sf_nzcv got %b exp 1001", nzcv); n_fail++;
    end
    cond_sel = 4'd11; #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      $display("FAIL sf_LT got %b exp 0", cond_true); n_fail++;
    end
    cond_sel = 4'd4; #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      $display("FAIL sf_MI got %b exp 1", cond_true); n_fail++;
    end
    drive_in(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_flags !== 4'b0100 || bus.out_set_flags !== 1'b0) begin
      $display("FAIL sf_gated_head got %b/%b exp 0100/0", bus.out_flags, bus.out_set_flags); n_fail++;
    end
    tick();
    n_checks++;
    if (nzcv !== 4'b1001) begin
      $display("FAIL sf_gated_nzcv got %b exp 1001", nzcv); n_fail++;
    end
    cond_sel = 4'd0; #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      $display("FAIL sf_gated_EQ got %b exp 0", cond_true); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [8];
    logic [3:0]  czv [8];
    logic [7:0]  sfv;
    logic [3:0]  exp_fl;
    res = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001,
            32'h0000_0000, 32'h1234_5678, 32'hF000_0000, 32'h0000_0010};
    // {C, Z, V, unused}
    czv = '{4'b1000, 4'b1000, 4'b0010, 4'b1010, 4'b1100, 4'b0000, 4'b1000, 4'b0110};
    sfv = 8'b0111_1011;  // bit i = set_flags of entry i; entry 7 has set_flags 0
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_in(1'b1, res[i], czv[i][3], czv[i][1], czv[i][2], sfv[i]);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        $display("FAIL stream_in_ready idx%0d got %b exp 1", i, bus.in_ready); n_fail++;
      end
      tick();
      exp_fl = {res[i][31], czv[i][2], czv[i][3], czv[i][1]};
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== res[i] || bus.out_flags !== exp_fl) begin
        $display("FAIL stream_head idx%0d got v=%b r=%h f=%b exp 1/%h/%b",
                 i, bus.out_valid, bus.out_result, bus.out_flags, res[i], exp_fl); n_fail++;
      end
    end
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL stream_drained got %b exp 0", bus.out_valid); n_fail++;
    end
    n_checks++;
    if (nzcv !== 4'b1010) begin
      $display("FAIL stream_nzcv got %b exp 1010", nzcv); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'hAAAA_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_in(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'hAAAA_0000) begin
      $display("FAIL mid_full got in_ready=%b head=%h exp 0/aaaa0000", bus.in_ready, bus.out_result); n_fail++;
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (nzcv !== 4'b0000) begin
      $display("FAIL mid_nzcv got %b exp 0000", nzcv); n_fail++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_flags !== 4'h0) begin
      $display("FAIL mid_out got v=%b r=%h f=%b exp 0/0/0000",
               bus.out_valid, bus.out_result, bus.out_flags); n_fail++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); n_fail++;
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || nzcv !== 4'b0000) begin
      $display("FAIL mid_settled got v=%b nzcv=%b exp 0/0000", bus.out_valid, nzcv); n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    cond_sel = 4'd0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_single_commit();
    test_backpressure();
    test_set_flags();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
